// File: rtl/dino_pkg.sv
// Shared types and constants for the dino scene engine: FSM state encoding, pixel colours
// and the unsigned in-range helper used by every sprite in-box test.
package dino_pkg;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StRun  = 2'd1,
    StOver = 2'd2
  } state_e;

  localparam logic [11:0] BLACK = 12'h000;
  localparam logic [11:0] WHITE = 12'hFFF;
  localparam logic [11:0] RED   = 12'hF00;

  localparam int unsigned OBS_ADDR_W  = 13;
  localparam int unsigned DINO_ADDR_W = 12;

  // 11-bit operands so that lo + len never wraps for 10-bit screen coordinates.
  function automatic logic in_range(input logic [10:0] p, input logic [10:0] lo,
                                    input logic [10:0] len);
    return (p >= lo) && (p < lo + len);
  endfunction

endpackage

// File: rtl/obstacle_channel.sv
// One obstacle lane: horizontal position with respawn, plus the registered in-box flag and
// sprite ROM address for the current pixel.
module obstacle_channel
  import dino_pkg::*;
#(
  parameter int unsigned OBS_W     = 49,
  parameter int unsigned OBS_H     = 80,
  parameter int unsigned INIT_X    = 550,
  parameter int unsigned RESPAWN_X = 630,
  parameter int unsigned X_MIN     = 10,
  parameter int unsigned OBS_Y     = 255
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  i_load,
  input  logic                  i_move,
  input  logic [3:0]            i_speed,
  input  logic                  i_pix_en,
  input  logic [9:0]            i_px,
  input  logic [8:0]            i_py,
  output logic                  o_inbox,
  output logic [OBS_ADDR_W-1:0] o_addr
);

  logic [9:0]            r_x;
  logic                  r_inbox;
  logic [OBS_ADDR_W-1:0] r_addr;

  logic [10:0]           w_px11, w_py11, w_x11, w_dx11, w_dy11;
  logic                  w_inbox;
  logic [OBS_ADDR_W-1:0] w_addr;

  assign w_px11  = {1'b0, i_px};
  assign w_py11  = {2'b0, i_py};
  assign w_x11   = {1'b0, r_x};
  assign w_dx11  = w_px11 - w_x11;
  assign w_dy11  = w_py11 - 11'(OBS_Y);
  assign w_inbox = in_range(w_px11, w_x11, 11'(OBS_W)) &&
                   in_range(w_py11, 11'(OBS_Y), 11'(OBS_H));
  assign w_addr  = OBS_ADDR_W'(w_dy11) * OBS_ADDR_W'(OBS_W) + OBS_ADDR_W'(w_dx11);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_x <= 10'(INIT_X);
    end else if (i_load) begin
      r_x <= 10'(INIT_X);
    end else if (i_move) begin
      // Respawn before the step would carry the obstacle past the left threshold.
      if (w_x11 < 11'(X_MIN) + {7'b0, i_speed}) begin
        r_x <= 10'(RESPAWN_X);
      end else begin
        r_x <= r_x - {6'b0, i_speed};
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_inbox <= 1'b0;
      r_addr  <= '0;
    end else if (i_pix_en) begin
      r_inbox <= w_inbox;
      r_addr  <= w_inbox ? w_addr : '0;
    end
  end

  assign o_inbox = r_inbox;
  assign o_addr  = r_addr;

endmodule

// File: rtl/dino_scene_engine.sv
// Dino runner scene engine: game FSM, obstacle motion/speed ramp, sprite addressing and the
// two-stage pixel colour pipeline. Define SCORE_EN to build the frames-survived counter.
module dino_scene_engine
  import dino_pkg::*;
#(
  parameter int unsigned NUM_OBS    = 2,
  parameter int unsigned OBS_W      = 49,
  parameter int unsigned OBS_H      = 80,
  parameter int unsigned DINO_W     = 60,
  parameter int unsigned DINO_H     = 60,
  parameter int unsigned SPAWN_X    = 550,
  parameter int unsigned OBS_GAP    = 200,
  parameter int unsigned RESPAWN_X  = 630,
  parameter int unsigned X_MIN      = 10,
  parameter int unsigned OBS_Y      = 255,
  parameter int unsigned SPEED_INIT = 1,
  parameter int unsigned SPEED_MAX  = 7,
  parameter int unsigned SPEED_STEP = 512
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          i_pix_en,
  input  logic                          i_frame_end,
  input  logic                          i_active,
  input  logic [9:0]                    i_px,
  input  logic [8:0]                    i_py,
  input  logic                          i_start,
  input  logic [9:0]                    i_dino_x,
  input  logic [8:0]                    i_dino_y,
  output logic [DINO_ADDR_W-1:0]        o_dino_addr,
  input  logic                          i_dino_bit,
  output logic [OBS_ADDR_W*NUM_OBS-1:0] o_obs_addr,
  input  logic [NUM_OBS-1:0]            i_obs_bit,
  input  logic                          i_bg_bit,
  output logic [11:0]                   o_rgb,
  output logic [1:0]                    o_state,
  output logic                          o_game_over,
  output logic [15:0]                   o_score
);

  state_e                 r_state, w_state_next;
  logic                   r_start_q;
  logic [3:0]             r_speed;
  logic [15:0]            r_frame_cnt;
  logic                   r_active_d1;
  logic                   r_dino_inbox;
  logic [DINO_ADDR_W-1:0] r_dino_addr;
  logic [11:0]            r_rgb;

  logic                   w_start_rise, w_load, w_collide, w_move;
  logic [NUM_OBS-1:0]     w_obs_inbox;
  logic [10:0]            w_px11, w_py11, w_dx11, w_dy11;
  logic                   w_dino_in, w_dino_px, w_obs_px;
  logic [DINO_ADDR_W-1:0] w_dino_addr;
  logic [11:0]            w_rgb_next;

  assign w_start_rise = i_start & ~r_start_q;
  assign w_load       = (r_state == StOver) && w_start_rise;
  assign w_dino_px    = r_dino_inbox & i_dino_bit;
  assign w_obs_px     = |(i_obs_bit & w_obs_inbox);
  assign w_collide    = i_pix_en && r_active_d1 && (r_state == StRun) && w_dino_px && w_obs_px;
  // A collision in the same cycle as frame_end freezes the scene.
  assign w_move       = i_frame_end && (r_state == StRun) && !w_collide;

  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      StIdle:  if (w_start_rise) w_state_next = StRun;
      StRun:   if (w_collide) w_state_next = StOver;
      StOver:  if (w_start_rise) w_state_next = StIdle;
      default: w_state_next = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state   <= StIdle;
      r_start_q <= 1'b0;
    end else begin
      r_state   <= w_state_next;
      r_start_q <= i_start;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_speed     <= 4'(SPEED_INIT);
      r_frame_cnt <= '0;
    end else if (w_load) begin
      r_speed     <= 4'(SPEED_INIT);
      r_frame_cnt <= '0;
    end else if (w_move) begin
      if (r_frame_cnt == 16'(SPEED_STEP - 1)) begin
        r_frame_cnt <= '0;
        if (r_speed < 4'(SPEED_MAX)) r_speed <= r_speed + 4'd1;
      end else begin
        r_frame_cnt <= r_frame_cnt + 16'd1;
      end
    end
  end

  for (genvar g = 0; g < NUM_OBS; g++) begin : g_obs
    obstacle_channel #(
      .OBS_W     (OBS_W),
      .OBS_H     (OBS_H),
      .INIT_X    (SPAWN_X + g * OBS_GAP),
      .RESPAWN_X (RESPAWN_X),
      .X_MIN     (X_MIN),
      .OBS_Y     (OBS_Y)
    ) u_obs (
      .clk      (clk),
      .reset    (reset),
      .i_load   (w_load),
      .i_move   (w_move),
      .i_speed  (r_speed),
      .i_pix_en (i_pix_en),
      .i_px     (i_px),
      .i_py     (i_py),
      .o_inbox  (w_obs_inbox[g]),
      .o_addr   (o_obs_addr[OBS_ADDR_W*g +: OBS_ADDR_W])
    );
  end

  assign w_px11      = {1'b0, i_px};
  assign w_py11      = {2'b0, i_py};
  assign w_dx11      = w_px11 - {1'b0, i_dino_x};
  assign w_dy11      = w_py11 - {2'b0, i_dino_y};
  assign w_dino_in   = in_range(w_px11, {1'b0, i_dino_x}, 11'(DINO_W)) &&
                       in_range(w_py11, {2'b0, i_dino_y}, 11'(DINO_H));
  assign w_dino_addr = DINO_ADDR_W'(w_dy11) * DINO_ADDR_W'(DINO_W) + DINO_ADDR_W'(w_dx11);

  always_comb begin
    w_rgb_next = WHITE;
    if (!r_active_d1) begin
      w_rgb_next = BLACK;
    end else if (w_dino_px) begin
      w_rgb_next = (r_state == StOver) ? RED : BLACK;
    end else if (w_obs_px || i_bg_bit) begin
      w_rgb_next = BLACK;
    end
  end

  // Stage 1 registers address/in-box/active; stage 2 combines ROM data into the colour.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_active_d1  <= 1'b0;
      r_dino_inbox <= 1'b0;
      r_dino_addr  <= '0;
      r_rgb        <= '0;
    end else if (i_pix_en) begin
      r_active_d1  <= i_active;
      r_dino_inbox <= w_dino_in;
      r_dino_addr  <= w_dino_in ? w_dino_addr : '0;
      r_rgb        <= w_rgb_next;
    end
  end

`ifdef SCORE_EN
  logic [15:0] r_score;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_score <= '0;
    end else if ((r_state == StIdle) && w_start_rise) begin
      r_score <= '0;
    end else if (w_move && (r_score != 16'hFFFF)) begin
      r_score <= r_score + 16'd1;
    end
  end

  assign o_score = r_score;
`else
  assign o_score = '0;
`endif

  assign o_dino_addr = r_dino_addr;
  assign o_rgb       = r_rgb;
  assign o_state     = r_state;
  assign o_game_over = (r_state == StOver);

endmodule

// File: tb/tb_dino_scene_engine.sv
// Directed bench for dino_scene_engine: reset, pixel pipeline, collision, motion/speed ramp,
// score and asynchronous reset, each scenario checked against hand-computed values.
module tb_dino_scene_engine;

  logic        clk = 1'b0;
  logic        reset;
  logic        pix_en;
  logic        frame_end;
  logic        active;
  logic [9:0]  px;
  logic [8:0]  py;
  logic        start;
  logic [9:0]  dino_x;
  logic [8:0]  dino_y;
  logic [11:0] dino_addr;
  logic        dino_bit;
  logic [25:0] obs_addr;
  logic [1:0]  obs_bit;
  logic        bg_bit;
  logic [11:0] rgb;
  logic [1:0]  state;
  logic        game_over;
  logic [15:0] score;

  int checks = 0;
  int failures = 0;

  dino_scene_engine dut (
    .clk         (clk),
    .reset       (reset),
    .i_pix_en    (pix_en),
    .i_frame_end (frame_end),
    .i_active    (active),
    .i_px        (px),
    .i_py        (py),
    .i_start     (start),
    .i_dino_x    (dino_x),
    .i_dino_y    (dino_y),
    .o_dino_addr (dino_addr),
    .i_dino_bit  (dino_bit),
    .o_obs_addr  (obs_addr),
    .i_obs_bit   (obs_bit),
    .i_bg_bit    (bg_bit),
    .o_rgb       (rgb),
    .o_state     (state),
    .o_game_over (game_over),
    .o_score     (score)
  );

  always #5 clk = ~clk;

  // 25 MHz enable: high for one clk period out of every four.
  initial begin
    pix_en = 1'b0;
    forever begin
      repeat (3) @(negedge clk);
      pix_en = 1'b1;
      @(negedge clk);
      pix_en = 1'b0;
    end
  end

  task automatic pix_step(input int n);
    for (int i = 0; i < n; i++) begin
      int guard = 0;
      @(posedge clk);
      while (pix_en !== 1'b1 && guard < 16) begin
        @(posedge clk);
        guard++;
      end
      if (guard >= 16) begin
        checks++; failures++;
        $display("FAIL pix_en_timeout: no pix_en within 16 clk");
      end
    end
    #1;
  endtask

  task automatic frames(input int n);
    @(negedge clk);
    frame_end = 1'b1;
    repeat (n) @(negedge clk);
    frame_end = 1'b0;
  endtask

  task automatic pulse_start();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset();
    reset = 1'b1; frame_end = 1'b0; active = 1'b0; px = '0; py = '0; start = 1'b0;
    dino_x = 10'd100; dino_y = 9'd275; dino_bit = 1'b0; obs_bit = 2'b00; bg_bit = 1'b0;
    #22;
    checks++;
    if (state !== 2'd0) begin failures++; $display("FAIL reset_state: got %0d want 0", state); end
    checks++;
    if (rgb !== 12'h000 || dino_addr !== 12'd0 || obs_addr !== 26'd0 || score !== 16'd0 ||
        game_over !== 1'b0) begin
      failures++;
      $display("FAIL reset_outputs: rgb=%h dino_addr=%0d obs_addr=%h score=%0d go=%b want 0s",
               rgb, dino_addr, obs_addr, score, game_over);
    end
    checks++;
    if (dut.g_obs[0].u_obs.r_x !== 10'd550 || dut.g_obs[1].u_obs.r_x !== 10'd750 ||
        dut.r_speed !== 4'd1) begin
      failures++;
      $display("FAIL reset_pos: x0=%0d x1=%0d speed=%0d want 550 750 1",
               dut.g_obs[0].u_obs.r_x, dut.g_obs[1].u_obs.r_x, dut.r_speed);
    end
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_pixel_path();
    // Empty pixel: no sprite covers (400,50) even with every ROM bit set.
    active = 1'b1; px = 10'd400; py = 9'd50; dino_bit = 1'b1; obs_bit = 2'b11; bg_bit = 1'b0;
    pix_step(2);
    checks++;
    if (rgb !== 12'hFFF) begin failures++; $display("FAIL empty_px: got %h want fff", rgb); end
    px = 10'd100; py = 9'd275;
    pix_step(1);
    checks++;
    if (rgb !== 12'hFFF) begin failures++; $display("FAIL latency_1: got %h want fff", rgb); end
    pix_step(1);
    checks++;
    if (rgb !== 12'h000) begin failures++; $display("FAIL dino_px: got %h want 000", rgb); end
    px = 10'd105; py = 9'd277;
    pix_step(1);
    checks++;
    if (dino_addr !== 12'd125) begin
      failures++; $display("FAIL dino_addr: got %0d want 125", dino_addr);
    end
    px = 10'd560; py = 9'd260;
    pix_step(1);
    checks++;
    if (obs_addr[12:0] !== 13'd255 || obs_addr[25:13] !== 13'd0 || dino_addr !== 12'd0) begin
      failures++;
      $display("FAIL obs_addr: got %0d/%0d dino=%0d want 255/0/0",
               obs_addr[12:0], obs_addr[25:13], dino_addr);
    end
    pix_step(1);
    checks++;
    if (rgb !== 12'h000) begin failures++; $display("FAIL obs_px: got %h want 000", rgb); end
    px = 10'd400; py = 9'd50; active = 1'b0;
    pix_step(2);
    checks++;
    if (rgb !== 12'h000) begin failures++; $display("FAIL blank: got %h want 000", rgb); end
    active = 1'b1; bg_bit = 1'b1;
    pix_step(2);
    checks++;
    if (rgb !== 12'h000) begin failures++; $display("FAIL bg_px: got %h want 000", rgb); end
    active = 1'b0; bg_bit = 1'b0; dino_bit = 1'b0; obs_bit = 2'b00;
    pix_step(1);
  endtask

  task automatic test_collision();
    pulse_start();
    checks++;
    if (state !== 2'd1 || dut.g_obs[0].u_obs.r_x !== 10'd550 ||
        dut.g_obs[1].u_obs.r_x !== 10'd750 || dut.r_speed !== 4'd1) begin
      failures++;
      $display("FAIL start_run: state=%0d x0=%0d x1=%0d speed=%0d want 1 550 750 1", state,
               dut.g_obs[0].u_obs.r_x, dut.g_obs[1].u_obs.r_x, dut.r_speed);
    end
    frames(460);
    checks++;
    if (dut.g_obs[0].u_obs.r_x !== 10'd90 || dut.g_obs[1].u_obs.r_x !== 10'd290) begin
      failures++;
      $display("FAIL move_460: x0=%0d x1=%0d want 90 290",
               dut.g_obs[0].u_obs.r_x, dut.g_obs[1].u_obs.r_x);
    end
    px = 10'd100; py = 9'd275; dino_bit = 1'b1; obs_bit = 2'b01; active = 1'b1;
    pix_step(3);
    checks++;
    if (state !== 2'd2 || game_over !== 1'b1) begin
      failures++; $display("FAIL collide: state=%0d go=%b want 2 1", state, game_over);
    end
    checks++;
    if (rgb !== 12'hF00) begin failures++; $display("FAIL over_red: got %h want f00", rgb); end
    frames(20);
    checks++;
    if (dut.g_obs[0].u_obs.r_x !== 10'd90) begin
      failures++; $display("FAIL frozen: x0=%0d want 90", dut.g_obs[0].u_obs.r_x);
    end
    active = 1'b0; dino_bit = 1'b0; obs_bit = 2'b00;
    @(negedge clk);
    start = 1'b1;
    repeat (6) @(negedge clk);
    checks++;
    if (state !== 2'd0 || dut.g_obs[0].u_obs.r_x !== 10'd550 || dut.r_speed !== 4'd1) begin
      failures++;
      $display("FAIL held_start: state=%0d x0=%0d speed=%0d want 0 550 1", state,
               dut.g_obs[0].u_obs.r_x, dut.r_speed);
    end
    start = 1'b0;
  endtask

  task automatic test_motion_speed();
    pulse_start();
    frames(512);
    checks++;
    if (dut.r_speed !== 4'd2 || dut.g_obs[0].u_obs.r_x !== 10'd38 ||
        dut.g_obs[1].u_obs.r_x !== 10'd238) begin
      failures++;
      $display("FAIL speed_512: speed=%0d x0=%0d x1=%0d want 2 38 238", dut.r_speed,
               dut.g_obs[0].u_obs.r_x, dut.g_obs[1].u_obs.r_x);
    end
    frames(13);
    checks++;
    if (dut.g_obs[0].u_obs.r_x !== 10'd12) begin
      failures++; $display("FAIL x_12: got %0d want 12", dut.g_obs[0].u_obs.r_x);
    end
    frames(1);
    checks++;
    if (dut.g_obs[0].u_obs.r_x !== 10'd10) begin
      failures++; $display("FAIL x_10: got %0d want 10", dut.g_obs[0].u_obs.r_x);
    end
    frames(1);
    checks++;
    if (dut.g_obs[0].u_obs.r_x !== 10'd630 || dut.g_obs[1].u_obs.r_x !== 10'd208) begin
      failures++;
      $display("FAIL respawn: x0=%0d x1=%0d want 630 208",
               dut.g_obs[0].u_obs.r_x, dut.g_obs[1].u_obs.r_x);
    end
    frames(2544);
    checks++;
    if (dut.r_speed !== 4'd6) begin
      failures++; $display("FAIL speed_3071: got %0d want 6", dut.r_speed);
    end
    frames(1);
    checks++;
    if (dut.r_speed !== 4'd7) begin
      failures++; $display("FAIL speed_3072: got %0d want 7", dut.r_speed);
    end
    frames(1024);
    checks++;
    if (dut.r_speed !== 4'd7 || state !== 2'd1) begin
      failures++;
      $display("FAIL speed_sat: speed=%0d state=%0d want 7 1", dut.r_speed, state);
    end
`ifdef SCORE_EN
    checks++;
    if (score !== 16'd4096) begin failures++; $display("FAIL score_4096: got %0d", score); end
`else
    checks++;
    if (score !== 16'd0) begin failures++; $display("FAIL score_off: got %0d want 0", score); end
`endif
  endtask

  task automatic test_score();
`ifdef SCORE_EN
    frames(61500);
    checks++;
    if (score !== 16'hFFFF) begin failures++; $display("FAIL score_sat: got %h want ffff", score); end
    // Sweep the dino across the lane until it meets an obstacle.
    dino_y = 9'd275; py = 9'd300; dino_bit = 1'b1; obs_bit = 2'b11; active = 1'b1;
    for (int x = 0; x <= 680 && state != 2'd2; x += 40) begin
      px = 10'(x); dino_x = 10'(x);
      pix_step(2);
    end
    pix_step(1);
    checks++;
    if (state !== 2'd2) begin failures++; $display("FAIL sweep_collide: state=%0d want 2", state); end
    active = 1'b0; dino_bit = 1'b0; obs_bit = 2'b00;
    pulse_start();
    pulse_start();
    checks++;
    if (state !== 2'd1 || score !== 16'd0) begin
      failures++; $display("FAIL score_clear: state=%0d score=%0d want 1 0", state, score);
    end
`endif
  endtask

  task automatic test_async_reset();
    @(posedge clk);
    #3;
    reset = 1'b1;
    #1;
    checks++;
    if (state !== 2'd0 || dut.g_obs[0].u_obs.r_x !== 10'd550 || score !== 16'd0) begin
      failures++;
      $display("FAIL async_reset: state=%0d x0=%0d score=%0d want 0 550 0", state,
               dut.g_obs[0].u_obs.r_x, score);
    end
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    test_reset();
    test_pixel_path();
    test_collision();
    test_motion_speed();
    test_score();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/dino_scene_engine.md
DINO_SCENE_ENGINE -- requirements
Module: dino_scene_engine

Interface
REQ-001 Parameters (name, default, meaning), one per line:
- NUM_OBS, 2, obstacle channels, legal 1..4
- OBS_W / OBS_H, 49 / 80, obstacle sprite size in pixels
- DINO_W / DINO_H, 60 / 60, dino sprite size in pixels
- SPAWN_X, 550, x of obstacle 0 at start
- OBS_GAP, 200, x spacing between channels at start
- RESPAWN_X, 630, x given to a respawned obstacle
- X_MIN, 10, left respawn threshold
- OBS_Y, 255, top y of all obstacles
- SPEED_INIT / SPEED_MAX, 1 / 7, pixels per frame
- SPEED_STEP, 512, RUN frames per speed increment
REQ-002 Ports (name, direction, width, meaning), one per line:
- clk, in, 1, 100 MHz system clock
- reset, in, 1, asynchronous, active-high
- pix_en, in, 1, 25 MHz pixel-advance enable
- frame_end, in, 1, one-cycle strobe between frames
- active, in, 1, visible-pixel flag
- px / py, in, 10 / 9, current pixel coordinate
- start, in, 1, start/restart request (level, sampled per clk)
- dino_x / dino_y, in, 10 / 9, dino top-left
- dino_addr, out, 12, dino ROM address
- dino_bit, in, 1, dino ROM data
- obs_addr, out, 13*NUM_OBS, per-channel obstacle ROM address
- obs_bit, in, NUM_OBS, obstacle ROM data
- bg_bit, in, 1, background pixel, aligned with ROM data
- rgb, out, 12, pixel colour
- state, out, 2, FSM state
- game_over, out, 1, high in OVER
- score, out, 16, frames survived

Function
REQ-003 FSM states: IDLE=0, RUN=1, OVER=2; IDLE->RUN on start; RUN->OVER on collision; OVER->IDLE on start.
REQ-004 On entering IDLE: obstacle i x = SPAWN_X + i*OBS_GAP, speed = SPEED_INIT, frame counter = 0.
REQ-005 On frame_end in RUN: per channel, if x < X_MIN + speed then x = RESPAWN_X, else x = x - speed; no movement in IDLE or OVER.
REQ-006 Speed increments by 1 every SPEED_STEP frame_end strobes in RUN, saturating at SPEED_MAX.
REQ-007 In-box test is registered on pix_en: px in [x, x+W) and py in [y, y+H), with 11-bit unsigned comparisons (no wrap).
REQ-008 Address = (py-y)*W + (px-x) when in-box, else 0; addresses are registered on pix_en with latency 1.
REQ-009 ROM bits and bg_bit are valid one pix_en after the address; in-box flags are delayed to match.
REQ-010 rgb is registered on pix_en, giving 2 pix_en of latency from px/py:
- 0 when active is low (active delayed 2 pix_en);
- dino pixel: 12'h000, or 12'hF00 in OVER;
- obstacle or bg pixel: 12'h000;
- otherwise: 12'hFFF.
REQ-011 Collision occurs when, on an active aligned pixel in RUN, dino_bit&dino_inbox is set together with any obs_bit&obs_inbox.
REQ-012 Collision and frame_end in the same cycle: OVER wins and no movement is applied.
REQ-013 start held high does not auto-cycle: each transition requires start to be low for at least one clk since the previous transition (rising-edge detect).

Reset
REQ-014 Reset is asynchronous and active-high:
- state = IDLE, with REQ-004 values loaded;
- rgb = 0, addresses = 0, score = 0, pipeline flags cleared.

Configuration
REQ-015 When SCORE_EN is defined: score increments on each frame_end in RUN, saturates at 16'hFFFF, and clears on IDLE->RUN.
REQ-016 When SCORE_EN is undefined: score is constant 0 and no counter logic is built.

Structure
REQ-017 Package dino_pkg holds the state enum and the colour constants (BLACK, WHITE, RED).
REQ-018 One sub-module, obstacle_channel, is instantiated NUM_OBS times; it holds position, respawn, in-box and address logic.

Verification
REQ-019 Reset, then start pulse -> state 1, obs x = 550 / 750, speed 1.
REQ-020 x = 10, speed 1, frame_end -> x = 630; with x = 11 -> x = 10.
REQ-021 512 RUN frames -> speed 2; 4096 frames -> speed stays 7.
REQ-022 dino at (100, 275), obstacle at x = 90, overlapping opaque bits -> game_over within 3 pix_en, obstacles frozen, dino drawn F00.
REQ-023 px = 100, py = 275 inside dino with dino_bit = 1 -> rgb = 000 exactly 2 pix_en later; active = 0 -> rgb = 000; empty pixel -> FFF.
REQ-024 SCORE_EN defined, 70000 RUN frames -> score = FFFF; restart -> score = 0.
